id_stage: RTL and testbench

- Instruction-decode / operand-fetch stage of the rv32 pipeline, directly upstream of the ALU/execute stage.
- Decodes the RV32I instruction and drives rs1/rs2 addresses into register_file.
- Picks up read data, with write-back bypass and an x0 override.
- Registers the decoded bundle into the ID/EX pipeline register behind a valid/ready handshake, with load-use stall and flush.

---
 rtl/id_stage.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode / operand-fetch stage feeding the ID/EX pipeline register.
module id_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] rf_rs1,
    output logic [REG_ADDR_W-1:0] rf_rs2,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_rs1_val,
    output logic [XLEN-1:0]       out_rs2_val,
    output logic [XLEN-1:0]       out_imm,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_we,
    output logic [3:0]            out_alu_op,
    output logic                  out_alu_src_imm,
    output logic                  out_alu_src_pc,
    output logic [2:0]            out_funct3,
    output logic                  out_is_load,
    output logic                  out_is_store,
    output logic                  out_is_branch,
    output logic                  out_is_jal,
    output logic                  out_is_jalr,
    output logic                  out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_we;
        logic [3:0]            alu_op;
        logic                  alu_src_imm;
        logic                  alu_src_pc;
        logic [2:0]            funct3;
        logic                  is_load;
        logic                  is_store;
        logic                  is_branch;
        logic                  is_jal;
        logic                  is_jalr;
        logic                  illegal;
    } bundle_t;

    // Operand pick: x0 reads zero, a same-cycle write-back wins over the stale RF read.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [REG_ADDR_W-1:0] idx,
        input logic [XLEN-1:0]       rdata,
        input logic                  we,
        input logic [REG_ADDR_W-1:0] wrd,
        input logic [XLEN-1:0]       wdata
    );
        if (idx == '0)               return '0;
        else if (we && (wrd == idx)) return wdata;
        else                         return rdata;
    endfunction

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic [31:0]           imm32;
    logic                  uses_rs1, uses_rs2, legal, writes_rd;
    logic                  hazard, accept;
    bundle_t               dec;
    bundle_t               bundle_d, bundle_q;
    logic                  valid_d, valid_q;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rs1    = REG_ADDR_W'(in_instr[19:15]);
    assign rs2    = REG_ADDR_W'(in_instr[24:20]);
    assign rd     = REG_ADDR_W'(in_instr[11:7]);
    assign rf_rs1 = rs1;
    assign rf_rs2 = rs2;

    // Instruction decode into the next bundle candidate.
    always_comb begin
        dec       = '0;
        imm32     = '0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        legal     = 1'b1;
        writes_rd = 1'b0;
        dec.pc     = in_pc;
        dec.funct3 = funct3;
        dec.rd     = rd;
        dec.alu_op = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
                legal = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                case (funct3)
                    3'b000:  dec.alu_op = in_instr[30] ? ALU_SUB : ALU_ADD;
                    3'b001:  dec.alu_op = ALU_SLL;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b101:  dec.alu_op = in_instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                writes_rd       = 1'b1;
                dec.alu_src_imm = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                case (funct3)
                    3'b000:  dec.alu_op = ALU_ADD;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        legal      = (funct7 == 7'b0000000);
                    end
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b101: begin
                        dec.alu_op = in_instr[30] ? ALU_SRA : ALU_SRL;
                        legal      = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                writes_rd       = 1'b1;
                dec.is_load     = 1'b1;
                dec.alu_src_imm = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                uses_rs2        = 1'b1;
                dec.is_store    = 1'b1;
                dec.alu_src_imm = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                legal = (funct3[2] == 1'b0) && (funct3 != 3'b011);
            end
            OPC_BRANCH: begin
                uses_rs2      = 1'b1;
                dec.is_branch = 1'b1;
                dec.alu_op    = ALU_SUB;
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_JAL: begin
                uses_rs1       = 1'b0;
                writes_rd      = 1'b1;
                dec.is_jal     = 1'b1;
                dec.alu_src_pc = 1'b1;
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                writes_rd      = 1'b1;
                dec.is_jalr    = 1'b1;
                dec.alu_src_pc = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                legal = (funct3 == 3'b000);
            end
            OPC_LUI: begin
                uses_rs1        = 1'b0;
                writes_rd       = 1'b1;
                dec.alu_op      = ALU_PASS_B;
                dec.alu_src_imm = 1'b1;
                imm32 = {in_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                uses_rs1        = 1'b0;
                writes_rd       = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.alu_src_pc  = 1'b1;
                imm32 = {in_instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        dec.imm     = XLEN'($signed(imm32));
        dec.rs1_val = pick_operand(rs1, rf_rdata1, wb_we, wb_rd, wb_data);
        dec.rs2_val = pick_operand(rs2, rf_rdata2, wb_we, wb_rd, wb_data);
        dec.rd_we   = writes_rd && (rd != '0);
        if (!legal) begin
            // Bad encodings still flow down the pipe so the trap carries its PC.
            dec.illegal   = 1'b1;
            dec.rd_we     = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jal    = 1'b0;
            dec.is_jalr   = 1'b0;
        end
    end

    // Load-use detection and handshake.
    always_comb begin
        hazard = valid_q && bundle_q.is_load && (bundle_q.rd != '0) &&
                 ((uses_rs1 && (bundle_q.rd == rs1)) || (uses_rs2 && (bundle_q.rd == rs2)));
        in_ready = (!valid_q || out_ready) && !hazard && !flush;
        accept   = in_valid && in_ready;
    end

    // Next-state for the ID/EX register: flush > accept > drain > hold.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = bundle_q.pc;
    assign out_rs1_val     = bundle_q.rs1_val;
    assign out_rs2_val     = bundle_q.rs2_val;
    assign out_imm         = bundle_q.imm;
    assign out_rd          = bundle_q.rd;
    assign out_rd_we       = bundle_q.rd_we;
    assign out_alu_op      = bundle_q.alu_op;
    assign out_alu_src_imm = bundle_q.alu_src_imm;
    assign out_alu_src_pc  = bundle_q.alu_src_pc;
    assign out_funct3      = bundle_q.funct3;
    assign out_is_load     = bundle_q.is_load;
    assign out_is_store    = bundle_q.is_store;
    assign out_is_branch   = bundle_q.is_branch;
    assign out_is_jal      = bundle_q.is_jal;
    assign out_is_jalr     = bundle_q.is_jalr;
    assign out_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, bypass, hazard, backpressure, flush, reset.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [3:0]  out_alu_op;
    logic        out_alu_src_imm, out_alu_src_pc;
    logic [2:0]  out_funct3;
    logic        out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr;
    logic        out_illegal;

    int vectors = 0;
    int errors  = 0;

    id_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_alu_op(out_alu_op), .out_alu_src_imm(out_alu_src_imm),
        .out_alu_src_pc(out_alu_src_pc), .out_funct3(out_funct3),
        .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_branch(out_is_branch), .out_is_jal(out_is_jal),
        .out_is_jalr(out_is_jalr), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0;
        rf_rdata1 = 32'h0; rf_rdata2 = 32'h0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        out_ready = 1'b0;
        #12;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", out_valid); end
        vectors++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0h want 0", out_rd); end
        vectors++; if (out_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %0h want 0", out_imm); end
        vectors++; if (out_alu_op !== 4'd0 || out_rd_we !== 1'b0) begin errors++; $display("FAIL reset_ctrl got %0h/%0h want 0/0", out_alu_op, out_rd_we); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
        rf_rdata1 = 32'h1234;
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0h want 1", out_valid); end
        vectors++; if (out_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d want 1", out_rd); end
        vectors++; if (out_imm !== 32'd5) begin errors++; $display("FAIL addi_imm got %0h want 5", out_imm); end
        vectors++; if (out_rs1_val !== 32'h0) begin errors++; $display("FAIL addi_x0 got %0h want 0", out_rs1_val); end
        vectors++; if (out_alu_op !== 4'd0) begin errors++; $display("FAIL addi_op got %0d want 0", out_alu_op); end
        vectors++; if (out_alu_src_imm !== 1'b1) begin errors++; $display("FAIL addi_srcimm got %0h want 1", out_alu_src_imm); end
        vectors++; if (out_rd_we !== 1'b1) begin errors++; $display("FAIL addi_rdwe got %0h want 1", out_rd_we); end
        vectors++; if (out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got %0h want 100", out_pc); end
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %0h want 0", out_valid); end
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; in_instr = 32'h001101B3; in_pc = 32'h104;
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF; rf_rdata1 = 32'h0; rf_rdata2 = 32'h11;
        #1;
        vectors++; if (rf_rs1 !== 5'd2 || rf_rs2 !== 5'd1) begin errors++; $display("FAIL rf_addr got %0d/%0d want 2/1", rf_rs1, rf_rs2); end
        step();
        vectors++; if (out_rs1_val !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs1 got %0h want deadbeef", out_rs1_val); end
        vectors++; if (out_rs2_val !== 32'h11) begin errors++; $display("FAIL bypass_rs2_rf got %0h want 11", out_rs2_val); end
        vectors++; if (out_rd !== 5'd3 || out_alu_src_imm !== 1'b0) begin errors++; $display("FAIL add_rd got %0d/%0h want 3/0", out_rd, out_alu_src_imm); end
        wb_rd = 5'd0;
        step();
        vectors++; if (out_rs1_val !== 32'h0) begin errors++; $display("FAIL bypass_wbx0 got %0h want 0", out_rs1_val); end
        wb_rd = 5'd1; wb_data = 32'hCAFEF00D; rf_rdata1 = 32'h77;
        step();
        vectors++; if (out_rs2_val !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_rs2 got %0h want cafef00d", out_rs2_val); end
        vectors++; if (out_rs1_val !== 32'h77) begin errors++; $display("FAIL rs1_rf got %0h want 77", out_rs1_val); end
        wb_we = 1'b0;
        step();
        vectors++; if (out_rs2_val !== 32'h11) begin errors++; $display("FAIL nowb_rs2 got %0h want 11", out_rs2_val); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; in_instr = 32'h0000A103; out_ready = 1'b1;
        step();
        vectors++; if (out_is_load !== 1'b1 || out_rd !== 5'd2 || out_funct3 !== 3'b010) begin errors++; $display("FAIL lw_decode got %0h/%0d/%0h want 1/2/2", out_is_load, out_rd, out_funct3); end
        in_instr = 32'h001101B3;
        #1;
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got %0h want 0", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0h want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %0h want 1", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd3) begin errors++; $display("FAIL lu_accept got %0h/%0d want 1/3", out_valid, out_rd); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_instr = 32'h00700293; out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_instr = 32'h00900313;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %0h want 0", i, in_ready); end
            step();
            vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_imm !== 32'd7) begin errors++; $display("FAIL bp_hold%0d got %0h/%0d/%0h want 1/5/7", i, out_valid, out_rd, out_imm); end
        end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume got %0h want 1", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_imm !== 32'd9) begin errors++; $display("FAIL bp_next got %0h/%0d/%0h want 1/6/9", out_valid, out_rd, out_imm); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = 32'h00700293; out_ready = 1'b1;
        step();
        out_ready = 1'b0; flush = 1'b1; in_instr = 32'h00900313;
        #1;
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0h want 0", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got %0h want 0", out_valid); end
        flush = 1'b0; in_valid = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %0h want 0", out_valid); end
    endtask

    task automatic test_decode_sweep();
        in_valid = 1'b1; out_ready = 1'b1;
        in_instr = 32'h12345037;
        step();
        vectors++; if (out_imm !== 32'h12345000 || out_alu_op !== 4'd10) begin errors++; $display("FAIL lui got %0h/%0d want 12345000/10", out_imm, out_alu_op); end
        vectors++; if (out_rd_we !== 1'b0) begin errors++; $display("FAIL lui_x0 got %0h want 0", out_rd_we); end
        in_instr = 32'hFE000EE3;
        step();
        vectors++; if (out_imm !== 32'hFFFFFFFC || out_is_branch !== 1'b1) begin errors++; $display("FAIL beq got %0h/%0h want fffffffc/1", out_imm, out_is_branch); end
        vectors++; if (out_alu_op !== 4'd1 || out_rd_we !== 1'b0) begin errors++; $display("FAIL beq_ctrl got %0d/%0h want 1/0", out_alu_op, out_rd_we); end
        in_instr = 32'h4030D093;
        step();
        vectors++; if (out_alu_op !== 4'd7 || out_imm[4:0] !== 5'd3) begin errors++; $display("FAIL srai got %0d/%0d want 7/3", out_alu_op, out_imm[4:0]); end
        in_instr = 32'h0020A423;
        step();
        vectors++; if (out_is_store !== 1'b1 || out_imm !== 32'd8 || out_rd_we !== 1'b0) begin errors++; $display("FAIL sw got %0h/%0h/%0h want 1/8/0", out_is_store, out_imm, out_rd_we); end
        in_instr = 32'h00000FFF;
        step();
        vectors++; if (out_illegal !== 1'b1 || out_rd_we !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL illegal got %0h/%0h/%0h want 1/0/1", out_illegal, out_rd_we, out_valid); end
        vectors++; if ({out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr} !== 5'b0) begin errors++; $display("FAIL illegal_flags got %0b want 0", {out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr}); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_instr = 32'h00700293; out_ready = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got %0h want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_imm !== 32'h0) begin errors++; $display("FAIL rmid_clear got %0h/%0d/%0h want 0/0/0", out_valid, out_rd, out_imm); end
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got %0h want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_backpressure();
        test_flush();
        test_decode_sweep();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
